// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution control path.
// Holds the default tile geometry, the derived tile sizes in words and the
// loader state encoding.
package conv_pkg;

   localparam int TN  = 16;
   localparam int TM  = 16;
   localparam int TR  = 64;
   localparam int TC  = 16;
   localparam int KSZ = 3;

   localparam int FM_TILE_WORDS = TM * TR * TC;
   localparam int W_TILE_WORDS  = TN * TM * KSZ * KSZ;
   localparam int KERNEL_SIZE   = KSZ * KSZ;

   // Width of each nested stream index (row, column, channel, kernel tap).
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD_FM = 2'd1,
      LOAD_W  = 2'd2,
      COMPUTE = 2'd3
   } loader_state_t;

endpackage

// File: rtl/conv_tile_loader_nest_counter.sv
// Three-level wrapping counter that walks a stream in order idx2, idx1, idx0
// (idx0 innermost).
// Ports:
//   clk, rst   clock and synchronous active-low reset
//   i_clr      synchronous clear to zero
//   i_en       advance one position
//   o_idx2..0  current indices
//   o_last     all three indices sit at their maxima
module nest_counter #(
   parameter int W    = 16,
   parameter int MAX2 = 1,
   parameter int MAX1 = 1,
   parameter int MAX0 = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_idx2,
   output logic [W-1:0] o_idx1,
   output logic [W-1:0] o_idx0,
   output logic         o_last
);

   logic [W-1:0] r_idx2;
   logic [W-1:0] r_idx1;
   logic [W-1:0] r_idx0;
   logic         w_wrap0;
   logic         w_wrap1;
   logic         w_wrap2;

   assign w_wrap0 = (r_idx0 == W'(MAX0));
   assign w_wrap1 = (r_idx1 == W'(MAX1));
   assign w_wrap2 = (r_idx2 == W'(MAX2));

   always_ff @(posedge clk) begin
      if (!rst || i_clr) begin
         r_idx2 <= '0;
         r_idx1 <= '0;
         r_idx0 <= '0;
      end else if (i_en) begin
         if (w_wrap0) begin
            r_idx0 <= '0;
            if (w_wrap1) begin
               r_idx1 <= '0;
               r_idx2 <= w_wrap2 ? '0 : r_idx2 + W'(1);
            end else begin
               r_idx1 <= r_idx1 + W'(1);
            end
         end else begin
            r_idx0 <= r_idx0 + W'(1);
         end
      end
   end

   assign o_idx2 = r_idx2;
   assign o_idx1 = r_idx1;
   assign o_idx0 = r_idx0;
   assign o_last = w_wrap2 && w_wrap1 && w_wrap0;

endmodule

// File: rtl/conv_tile_loader.sv
// Tile loader: receives one tile (input FM then weights) as a valid/ready
// word stream, scatters it into the X-banked FM buffer and the weight buffer,
// then holds conv_computing_start until the compute path reports done.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   load_start               rising edge starts a tile load (IDLE only)
//   in_data/valid/ready      input word stream
//   in_fm_wr_*               one-hot bank write into the FM buffer
//   weight_wr_*              weight buffer write
//   conv_computing_start     level, tile resident and compute running
//   conv_computing_done      one-cycle pulse from the control path
//   tile_done                one-cycle pulse after compute finishes
//   busy                     loader not idle
//
// state   | meaning
// IDLE    | waiting for a load_start rising edge
// LOAD_FM | accepting FM words, channel / row / column order
// LOAD_W  | accepting weight words, out-ch / in-ch / kernel-tap order
// COMPUTE | tile resident, waiting for conv_computing_done
module conv_tile_loader
   import conv_pkg::*;
#(
   parameter int AW = 16,
   parameter int DW = 32,
   parameter int Tn = TN,
   parameter int Tm = TM,
   parameter int Tr = TR,
   parameter int Tc = TC,
   parameter int K  = KSZ,
   parameter int X  = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_start,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [X-1:0]  in_fm_wr_ena,
   output logic [AW-1:0] in_fm_wr_addr,
   output logic [DW-1:0] in_fm_wr_data,
   output logic          weight_wr_ena,
   output logic [AW-1:0] weight_wr_addr,
   output logic [DW-1:0] weight_wr_data,
   output logic          conv_computing_start,
   input  logic          conv_computing_done,
   output logic          tile_done,
   output logic          busy
);

   localparam int  KK       = K * K;
   localparam longint FM_WORDS = longint'(Tm) * Tr * Tc;
   localparam longint W_WORDS  = longint'(Tn) * Tm * K * K;
   localparam longint ADDR_SPAN = longint'(1) << AW;

   if (Tm % X != 0) begin : g_bad_banks
      $error("conv_tile_loader: Tm must be a multiple of X");
   end
   if (FM_WORDS > ADDR_SPAN) begin : g_bad_fm_span
      $error("conv_tile_loader: FM tile does not fit in AW");
   end
   if (W_WORDS > ADDR_SPAN) begin : g_bad_w_span
      $error("conv_tile_loader: weight tile does not fit in AW");
   end

   loader_state_t r_state;
   logic          r_load_start_d;
   logic          r_in_ready;
   logic          r_busy;
   logic          r_start;
   logic          r_tile_done;
   logic [X-1:0]  r_fm_wr_ena;
   logic [AW-1:0] r_fm_wr_addr;
   logic [DW-1:0] r_fm_wr_data;
   logic          r_w_wr_ena;
   logic [AW-1:0] r_w_wr_addr;
   logic [DW-1:0] r_w_wr_data;

   logic             w_ls_rise;
   logic             w_fm_acc;
   logic             w_w_acc;
   logic             w_cnt_clr;
   logic [CNT_W-1:0] w_fm_ch;
   logic [CNT_W-1:0] w_fm_r;
   logic [CNT_W-1:0] w_fm_c;
   logic             w_fm_last;
   logic [CNT_W-1:0] w_w_n;
   logic [CNT_W-1:0] w_w_m;
   logic [CNT_W-1:0] w_w_k;
   logic             w_w_last;
   logic [31:0]      w_fm_addr_full;
   logic [31:0]      w_w_addr_full;
   logic [X-1:0]     w_bank_onehot;

   assign w_ls_rise = load_start && !r_load_start_d;
   assign w_fm_acc  = in_valid && r_in_ready && (r_state == LOAD_FM);
   assign w_w_acc   = in_valid && r_in_ready && (r_state == LOAD_W);
   // Counters sit at zero while idle so each load starts from index 0.
   assign w_cnt_clr = (r_state == IDLE);

   nest_counter #(
      .W    (CNT_W),
      .MAX2 (Tm - 1),
      .MAX1 (Tr - 1),
      .MAX0 (Tc - 1)
   ) u_fm_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_cnt_clr),
      .i_en   (w_fm_acc),
      .o_idx2 (w_fm_ch),
      .o_idx1 (w_fm_r),
      .o_idx0 (w_fm_c),
      .o_last (w_fm_last)
   );

   nest_counter #(
      .W    (CNT_W),
      .MAX2 (Tn - 1),
      .MAX1 (Tm - 1),
      .MAX0 (KK - 1)
   ) u_w_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_cnt_clr),
      .i_en   (w_w_acc),
      .o_idx2 (w_w_n),
      .o_idx1 (w_w_m),
      .o_idx0 (w_w_k),
      .o_last (w_w_last)
   );

   // Channels interleave across banks; each bank holds Tm/X full planes.
   assign w_bank_onehot  = X'(1) << (32'(w_fm_ch) % 32'(X));
   assign w_fm_addr_full = (32'(w_fm_ch) / 32'(X)) * 32'(Tr * Tc)
                         + 32'(w_fm_r) * 32'(Tc) + 32'(w_fm_c);
   assign w_w_addr_full  = (32'(w_w_n) * 32'(Tm) + 32'(w_w_m)) * 32'(KK)
                         + 32'(w_w_k);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state        <= IDLE;
         r_load_start_d <= 1'b0;
         r_in_ready     <= 1'b0;
         r_busy         <= 1'b0;
         r_start        <= 1'b0;
         r_tile_done    <= 1'b0;
         r_fm_wr_ena    <= '0;
         r_fm_wr_addr   <= '0;
         r_fm_wr_data   <= '0;
         r_w_wr_ena     <= 1'b0;
         r_w_wr_addr    <= '0;
         r_w_wr_data    <= '0;
      end else begin
         r_load_start_d <= load_start;
         r_fm_wr_ena    <= '0;
         r_w_wr_ena     <= 1'b0;
         r_tile_done    <= 1'b0;

         if (w_fm_acc) begin
            r_fm_wr_ena  <= w_bank_onehot;
            r_fm_wr_addr <= AW'(w_fm_addr_full);
            r_fm_wr_data <= in_data;
         end
         if (w_w_acc) begin
            r_w_wr_ena  <= 1'b1;
            r_w_wr_addr <= AW'(w_w_addr_full);
            r_w_wr_data <= in_data;
         end

         case (r_state)
            IDLE: begin
               if (w_ls_rise) begin
                  r_state    <= LOAD_FM;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            LOAD_FM: begin
               if (w_fm_acc && w_fm_last) begin
                  r_state <= LOAD_W;
               end
            end
            LOAD_W: begin
               if (w_w_acc && w_w_last) begin
                  r_state    <= COMPUTE;
                  r_in_ready <= 1'b0;
               end
            end
            COMPUTE: begin
               // Start is raised one cycle after entry so the last weight
               // write has already been presented to the buffer.
               if (conv_computing_done) begin
                  r_state     <= IDLE;
                  r_start     <= 1'b0;
                  r_busy      <= 1'b0;
                  r_tile_done <= 1'b1;
               end else begin
                  r_start <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready             = r_in_ready;
   assign busy                 = r_busy;
   assign conv_computing_start = r_start;
   assign tile_done            = r_tile_done;
   assign in_fm_wr_ena         = r_fm_wr_ena;
   assign in_fm_wr_addr        = r_fm_wr_addr;
   assign in_fm_wr_data        = r_fm_wr_data;
   assign weight_wr_ena        = r_w_wr_ena;
   assign weight_wr_addr       = r_w_wr_addr;
   assign weight_wr_data       = r_w_wr_data;

endmodule

// File: tb/tb_conv_tile_loader.sv
module tb_conv_tile_loader;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int TN = 4;
   localparam int TM = 4;
   localparam int TR = 4;
   localparam int TC = 4;
   localparam int KS = 3;
   localparam int X  = 4;
   localparam int KK = KS * KS;
   localparam int FM = TM * TR * TC;
   localparam int WW = TN * TM * KK;
   localparam int TOTAL = FM + WW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          load_start = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [X-1:0]  in_fm_wr_ena;
   logic [AW-1:0] in_fm_wr_addr;
   logic [DW-1:0] in_fm_wr_data;
   logic          weight_wr_ena;
   logic [AW-1:0] weight_wr_addr;
   logic [DW-1:0] weight_wr_data;
   logic          conv_computing_start;
   logic          conv_computing_done = 1'b0;
   logic          tile_done;
   logic          busy;

   conv_tile_loader #(
      .AW(AW), .DW(DW), .Tn(TN), .Tm(TM), .Tr(TR), .Tc(TC), .K(KS), .X(X)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .load_start           (load_start),
      .in_data              (in_data),
      .in_valid             (in_valid),
      .in_ready             (in_ready),
      .in_fm_wr_ena         (in_fm_wr_ena),
      .in_fm_wr_addr        (in_fm_wr_addr),
      .in_fm_wr_data        (in_fm_wr_data),
      .weight_wr_ena        (weight_wr_ena),
      .weight_wr_addr       (weight_wr_addr),
      .weight_wr_data       (weight_wr_data),
      .conv_computing_start (conv_computing_start),
      .conv_computing_done  (conv_computing_done),
      .tile_done            (tile_done),
      .busy                 (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  ena;
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   int  errors = 0;
   int  checks = 0;
   wr_t fm_log[$];
   wr_t w_log[$];
   int  n_spurious = 0;
   int  n_missing = 0;
   logic prev_acc = 1'b0;
   logic mon_wr;
   logic [31:0] tile_data [TOTAL];

   // Observation only: record every buffer write and whether it lines up
   // with an accept on the preceding edge.
   always @(negedge clk) begin
      mon_wr = (in_fm_wr_ena != '0) || weight_wr_ena;
      if (in_fm_wr_ena != '0) fm_log.push_back({in_fm_wr_ena, in_fm_wr_addr, in_fm_wr_data});
      if (weight_wr_ena) w_log.push_back({4'b0001, weight_wr_addr, weight_wr_data});
      if (mon_wr && !prev_acc) n_spurious++;
      if (!mon_wr && prev_acc) n_missing++;
      prev_acc = in_valid && in_ready && rst;
   end

   // Reference mapping of stream beat j to its buffer location.
   function automatic void exp_beat(input int j, output logic [3:0] ena, output logic [15:0] addr);
      int ch, r, c, i, n, m, k;
      if (j < FM) begin
         ch   = j / (TR * TC);
         r    = (j / TC) % TR;
         c    = j % TC;
         ena  = 4'(1 << (ch % X));
         addr = 16'((ch / X) * TR * TC + r * TC + c);
      end else begin
         i    = j - FM;
         n    = i / (TM * KK);
         m    = (i / KK) % TM;
         k    = i % KK;
         ena  = 4'b0001;
         addr = 16'((n * TM + m) * KK + k);
      end
   endfunction

   task automatic new_data(input int base, input bit random);
      for (int j = 0; j < TOTAL; j++)
         tile_data[j] = random ? $urandom : 32'(base + j);
   endtask

   task automatic clear_logs();
      fm_log.delete();
      w_log.delete();
      n_spurious = 0;
      n_missing = 0;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
   endtask

   task automatic drive_tile(input int n_words, input int gap_pct, input int ls_at,
                             input int done_at, output int ok);
      int  j = 0;
      int  cyc = 0;
      logic acc;
      while (j < n_words && cyc < 5000) begin
         in_valid = ($urandom_range(99) >= gap_pct);
         in_data  = tile_data[j];
         load_start = (ls_at >= 0) && (j >= ls_at) && (j < ls_at + 3);
         conv_computing_done = (done_at >= 0) && (j == done_at);
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) j++;
         cyc++;
      end
      in_valid = 1'b0;
      load_start = 1'b0;
      conv_computing_done = 1'b0;
      ok = (j == n_words) ? 1 : 0;
   endtask

   task automatic wait_start(output int ok);
      int cyc = 0;
      while (cyc < 100) begin
         @(negedge clk);
         if (conv_computing_start) break;
         cyc++;
      end
      ok = conv_computing_start ? 1 : 0;
      @(posedge clk); #1;
   endtask

   task automatic pulse_done();
      conv_computing_done = 1'b1;
      @(posedge clk); #1;
      conv_computing_done = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if ({in_ready, in_fm_wr_ena, in_fm_wr_addr, in_fm_wr_data, weight_wr_ena, weight_wr_addr,
           weight_wr_data, conv_computing_start, tile_done, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b ena=%b start=%b busy=%b, all required 0",
                  in_ready, in_fm_wr_ena, conv_computing_start, busy);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b ready=%b required 0 0", busy, in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_full_tile();
      int ok;
      logic [3:0] e_ena;
      logic [15:0] e_addr;
      wr_t g;
      clear_logs();
      new_data(0, 0);
      start_load();
      drive_tile(TOTAL, 0, -1, -1, ok);
      checks++;
      if (ok != 1) begin errors++; $display("FAIL full_stream_timeout: accepted less than %0d", TOTAL); end
      @(negedge clk);
      checks++;
      if (conv_computing_start !== 1'b0 || weight_wr_ena !== 1'b1 || weight_wr_addr !== 16'd143) begin
         errors++;
         $display("FAIL start_early: start=%b wena=%b waddr=%0d required 0 1 143",
                  conv_computing_start, weight_wr_ena, weight_wr_addr);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (conv_computing_start !== 1'b1) begin
         errors++;
         $display("FAIL start_rise: start=%b required 1 two cycles after last beat", conv_computing_start);
      end
      @(posedge clk); #1;
      pulse_done();
      checks++;
      if (fm_log.size() != FM || w_log.size() != WW) begin
         errors++;
         $display("FAIL full_counts: fm=%0d w=%0d required %0d %0d", fm_log.size(), w_log.size(), FM, WW);
      end else begin
         checks++;
         if (fm_log[17].ena !== 4'b0010 || fm_log[17].addr !== 16'd1) begin
            errors++;
            $display("FAIL fm_word17: ena=%b addr=%0d required 0010 1", fm_log[17].ena, fm_log[17].addr);
         end
         for (int j = 0; j < TOTAL; j++) begin
            exp_beat(j, e_ena, e_addr);
            g = (j < FM) ? fm_log[j] : w_log[j - FM];
            checks++;
            if (g.ena !== e_ena || g.addr !== e_addr || g.data !== tile_data[j]) begin
               errors++;
               $display("FAIL full_beat%0d: ena=%b addr=%0d data=%h required %b %0d %h",
                        j, g.ena, g.addr, g.data, e_ena, e_addr, tile_data[j]);
            end
         end
      end
      checks++;
      if (n_spurious != 0 || n_missing != 0) begin
         errors++;
         $display("FAIL full_write_timing: spurious=%0d missing=%0d required 0 0", n_spurious, n_missing);
      end
   endtask

   task automatic test_random_gaps();
      int ok;
      logic [3:0] e_ena;
      logic [15:0] e_addr;
      wr_t g;
      clear_logs();
      new_data(0, 0);
      start_load();
      drive_tile(TOTAL, 50, -1, -1, ok);
      checks++;
      if (ok != 1) begin errors++; $display("FAIL gaps_stream_timeout: accepted less than %0d", TOTAL); end
      wait_start(ok);
      checks++;
      if (ok != 1) begin errors++; $display("FAIL gaps_start: start=0 required 1"); end
      pulse_done();
      checks++;
      if (fm_log.size() != FM || w_log.size() != WW) begin
         errors++;
         $display("FAIL gaps_counts: fm=%0d w=%0d required %0d %0d", fm_log.size(), w_log.size(), FM, WW);
      end else begin
         for (int j = 0; j < TOTAL; j++) begin
            exp_beat(j, e_ena, e_addr);
            g = (j < FM) ? fm_log[j] : w_log[j - FM];
            checks++;
            if (g.ena !== e_ena || g.addr !== e_addr || g.data !== tile_data[j]) begin
               errors++;
               $display("FAIL gaps_beat%0d: ena=%b addr=%0d data=%h required %b %0d %h",
                        j, g.ena, g.addr, g.data, e_ena, e_addr, tile_data[j]);
            end
         end
      end
      checks++;
      if (n_spurious != 0 || n_missing != 0) begin
         errors++;
         $display("FAIL gaps_write_timing: spurious=%0d missing=%0d required 0 0", n_spurious, n_missing);
      end
   endtask

   task automatic test_done_and_reload();
      int ok;
      logic [3:0] e_ena;
      logic [15:0] e_addr;
      wr_t g;
      new_data(0, 1);
      start_load();
      drive_tile(TOTAL, 20, -1, -1, ok);
      wait_start(ok);
      checks++;
      if (ok != 1) begin errors++; $display("FAIL done_start: start=0 required 1"); end
      repeat (9) @(posedge clk);
      #1;
      conv_computing_done = 1'b1;
      @(negedge clk);
      checks++;
      if (conv_computing_start !== 1'b1 || tile_done !== 1'b0) begin
         errors++;
         $display("FAIL done_cycle: start=%b tile_done=%b required 1 0", conv_computing_start, tile_done);
      end
      @(posedge clk); #1;
      conv_computing_done = 1'b0;
      @(negedge clk);
      checks++;
      if (conv_computing_start !== 1'b0 || tile_done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL after_done: start=%b tile_done=%b busy=%b required 0 1 0",
                  conv_computing_start, tile_done, busy);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (tile_done !== 1'b0) begin
         errors++;
         $display("FAIL tile_done_pulse: tile_done=%b required 0", tile_done);
      end
      @(posedge clk); #1;
      clear_logs();
      new_data(0, 1);
      start_load();
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL reload_busy: busy=%b required 1", busy); end
      @(posedge clk); #1;
      drive_tile(TOTAL, 30, -1, -1, ok);
      wait_start(ok);
      pulse_done();
      checks++;
      if (fm_log.size() != FM || w_log.size() != WW) begin
         errors++;
         $display("FAIL reload_counts: fm=%0d w=%0d required %0d %0d", fm_log.size(), w_log.size(), FM, WW);
      end else begin
         for (int j = 0; j < TOTAL; j++) begin
            exp_beat(j, e_ena, e_addr);
            g = (j < FM) ? fm_log[j] : w_log[j - FM];
            checks++;
            if (g.ena !== e_ena || g.addr !== e_addr || g.data !== tile_data[j]) begin
               errors++;
               $display("FAIL reload_beat%0d: ena=%b addr=%0d data=%h required %b %0d %h",
                        j, g.ena, g.addr, g.data, e_ena, e_addr, tile_data[j]);
            end
         end
      end
   endtask

   task automatic test_load_start_ignored();
      int ok;
      logic [3:0] e_ena;
      logic [15:0] e_addr;
      wr_t g;
      clear_logs();
      new_data(0, 1);
      start_load();
      drive_tile(TOTAL, 0, FM + 36, -1, ok);
      wait_start(ok);
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || conv_computing_start !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL ls_in_compute: busy=%b start=%b ready=%b required 1 1 0",
                  busy, conv_computing_start, in_ready);
      end
      @(posedge clk); #1;
      pulse_done();
      checks++;
      if (fm_log.size() != FM || w_log.size() != WW) begin
         errors++;
         $display("FAIL ls_counts: fm=%0d w=%0d required %0d %0d", fm_log.size(), w_log.size(), FM, WW);
      end else begin
         for (int j = 0; j < TOTAL; j++) begin
            exp_beat(j, e_ena, e_addr);
            g = (j < FM) ? fm_log[j] : w_log[j - FM];
            checks++;
            if (g.ena !== e_ena || g.addr !== e_addr || g.data !== tile_data[j]) begin
               errors++;
               $display("FAIL ls_beat%0d: ena=%b addr=%0d data=%h required %b %0d %h",
                        j, g.ena, g.addr, g.data, e_ena, e_addr, tile_data[j]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_load();
      int ok;
      logic [3:0] e_ena;
      logic [15:0] e_addr;
      wr_t g;
      new_data(0, 1);
      start_load();
      drive_tile(30, 0, -1, -1, ok);
      rst = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, in_fm_wr_ena, in_fm_wr_addr, in_fm_wr_data, weight_wr_ena, weight_wr_addr,
           weight_wr_data, conv_computing_start, tile_done, busy} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: ready=%b ena=%b addr=%0d busy=%b, all required 0",
                  in_ready, in_fm_wr_ena, in_fm_wr_addr, busy);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      clear_logs();
      new_data(0, 1);
      start_load();
      drive_tile(TOTAL, 25, -1, -1, ok);
      wait_start(ok);
      pulse_done();
      checks++;
      if (fm_log.size() != FM || w_log.size() != WW) begin
         errors++;
         $display("FAIL midreset_counts: fm=%0d w=%0d required %0d %0d", fm_log.size(), w_log.size(), FM, WW);
      end else begin
         for (int j = 0; j < TOTAL; j++) begin
            exp_beat(j, e_ena, e_addr);
            g = (j < FM) ? fm_log[j] : w_log[j - FM];
            checks++;
            if (g.ena !== e_ena || g.addr !== e_addr || g.data !== tile_data[j]) begin
               errors++;
               $display("FAIL midreset_beat%0d: ena=%b addr=%0d data=%h required %b %0d %h",
                        j, g.ena, g.addr, g.data, e_ena, e_addr, tile_data[j]);
            end
         end
      end
   endtask

   task automatic test_done_in_load_fm();
      int ok;
      logic [3:0] e_ena;
      logic [15:0] e_addr;
      wr_t g;
      clear_logs();
      new_data(0, 1);
      start_load();
      drive_tile(TOTAL, 0, -1, 20, ok);
      checks++;
      if (ok != 1) begin errors++; $display("FAIL early_done_stream: accepted less than %0d", TOTAL); end
      wait_start(ok);
      checks++;
      if (ok != 1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL early_done_start: start_seen=%0d busy=%b required 1 1", ok, busy);
      end
      pulse_done();
      checks++;
      if (fm_log.size() != FM || w_log.size() != WW) begin
         errors++;
         $display("FAIL early_done_counts: fm=%0d w=%0d required %0d %0d", fm_log.size(), w_log.size(), FM, WW);
      end else begin
         for (int j = 0; j < TOTAL; j++) begin
            exp_beat(j, e_ena, e_addr);
            g = (j < FM) ? fm_log[j] : w_log[j - FM];
            checks++;
            if (g.ena !== e_ena || g.addr !== e_addr || g.data !== tile_data[j]) begin
               errors++;
               $display("FAIL early_done_beat%0d: ena=%b addr=%0d data=%h required %b %0d %h",
                        j, g.ena, g.addr, g.data, e_ena, e_addr, tile_data[j]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_tile();
      test_random_gaps();
      test_done_and_reload();
      test_load_start_ignored();
      test_reset_mid_load();
      test_done_in_load_fm();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
